// File: rtl/cpu_clock_monitor_pkg.sv
// cpu_clock_monitor_pkg: phase encoding, tracker states and nominal cycle lengths for the CPU clock monitor
package cpu_clock_monitor_pkg;
  localparam logic [1:0] PH_00 = 2'd0;
  localparam logic [1:0] PH_01 = 2'd1;
  localparam logic [1:0] PH_11 = 2'd2;
  localparam logic [1:0] PH_10 = 2'd3;
  localparam int LEN_SLOW = 16;
  localparam int LEN_FAST = 8;
  typedef enum logic {SEARCH, TRACK} state_t;
  function automatic logic [1:0] to_phase(input logic e, input logic q);
    return e ? (q ? PH_11 : PH_10) : (q ? PH_01 : PH_00);
  endfunction
endpackage

// File: rtl/cpu_clock_sync.sv
// cpu_clock_sync: STAGES-deep 2-bit synchroniser with async reset
// ports: clk, rst (async, active high), d_i raw 2-bit input, q_o synchronised output
module cpu_clock_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);
  logic [STAGES-1:0][1:0] ff_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ff_q <= '0;
    else ff_q <= {ff_q[STAGES-2:0], d_i};
  assign q_o = ff_q[STAGES-1];
endmodule

// File: rtl/cpu_clock_monitor.sv
// cpu_clock_monitor: tracks 6809 E/Q quadrature, emits bus-cycle strobes, measures cycle length and lock
// ports: clk, reset (async, active high), E/Q CPU clocks in; addr/data strobes, cycle_end, cycle_len,
//        rate_fast, rate_odd, quad_error, locked, phase out
module cpu_clock_monitor
  import cpu_clock_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 2,
  parameter int LEN_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E,
  input  logic             Q,
  output logic             addr_strobe,
  output logic             data_strobe,
  output logic             cycle_end,
  output logic [LEN_W-1:0] cycle_len,
  output logic             rate_fast,
  output logic             rate_odd,
  output logic             quad_error,
  output logic             locked,
  output logic [1:0]       phase
);
  localparam logic [LEN_W-1:0] CNT_MAX = '1;
  localparam logic [2:0] LOCK_N = 3'(LOCK_CYCLES);
  logic [1:0] eq_s, prev_q;
  logic primed_q;
  state_t state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc, len_d;
  logic [2:0] lk_q, lk_d;
  logic as_d, ds_d, qe_d, odd_d, fast_d;
  logic chg, bad, efall;
  cpu_clock_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(reset),
    .d_i({E, Q}),
    .q_o(eq_s)
  );
  assign phase = to_phase(eq_s[1], eq_s[0]);
  assign locked = lk_q == LOCK_N;
  assign cnt_inc = cnt_q == CNT_MAX ? CNT_MAX : cnt_q + 1'b1;
  // the priming sample only loads prev_q, so no edge can be seen on it
  assign chg = primed_q && phase != prev_q;
  assign bad = chg && phase != prev_q + 2'd1;
  assign efall = chg && prev_q == PH_10 && phase == PH_00;
  always_comb begin
    state_d = state_q;
    cnt_d = efall ? '0 : cnt_inc;
    lk_d = lk_q;
    len_d = cycle_len;
    fast_d = rate_fast;
    as_d = 1'b0;
    ds_d = 1'b0;
    qe_d = 1'b0;
    odd_d = 1'b0;
    if (state_q == SEARCH) state_d = efall ? TRACK : SEARCH;
    else if (bad) begin
      qe_d = 1'b1;
      lk_d = '0;
      state_d = SEARCH;
    end else if (efall) begin
      ds_d = 1'b1;
      len_d = cnt_inc;
      fast_d = cnt_inc == LEN_W'(LEN_FAST);
      odd_d = cnt_inc != LEN_W'(LEN_FAST) && cnt_inc != LEN_W'(LEN_SLOW);
      lk_d = locked ? lk_q : lk_q + 3'd1;
    end else if (cnt_q == CNT_MAX) begin
      // clocks stalled long enough to saturate the length counter: drop lock quietly
      lk_d = '0;
      state_d = SEARCH;
    end else as_d = chg && phase == PH_01;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      primed_q <= 1'b0;
      prev_q <= PH_00;
      state_q <= SEARCH;
      cnt_q <= '0;
      lk_q <= '0;
      addr_strobe <= 1'b0;
      data_strobe <= 1'b0;
      cycle_end <= 1'b0;
      quad_error <= 1'b0;
      rate_odd <= 1'b0;
      rate_fast <= 1'b0;
      cycle_len <= '0;
    end else begin
      primed_q <= 1'b1;
      prev_q <= phase;
      state_q <= state_d;
      cnt_q <= cnt_d;
      lk_q <= lk_d;
      addr_strobe <= as_d;
      data_strobe <= ds_d;
      cycle_end <= ds_d;
      quad_error <= qe_d;
      rate_odd <= odd_d;
      rate_fast <= fast_d;
      cycle_len <= len_d;
    end
endmodule

// File: tb/tb_cpu_clock_monitor.sv
// tb_cpu_clock_monitor: scoreboard bench for cpu_clock_monitor against a timestamp-based reference model
module tb_cpu_clock_monitor;
  localparam int S = 2, LOCK = 2, LW = 5, MAXL = 31;
  logic clk = 0, reset = 1, E = 0, Q = 0;
  logic addr_strobe, data_strobe, cycle_end, rate_fast, rate_odd, quad_error, locked;
  logic [LW-1:0] cycle_len;
  logic [1:0] phase;
  typedef struct packed {
    int cyc;
    logic a, d, c, qe, odd;
    logic [LW-1:0] len;
    logic fast, lk;
  } ev_t;
  ev_t evq[$];
  ev_t act, want;
  int hist[int];
  int cyc = 0, checks = 0, failures = 0, cur_ph = 0, exp_ph, nx, n;
  bit mtrack = 0, mfast = 0;
  int prev_ph = 0, last_fall = 0, lk = 0, mlen = 0;

  cpu_clock_monitor #(.SYNC_STAGES(S), .LOCK_CYCLES(LOCK), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .E(E), .Q(Q),
    .addr_strobe(addr_strobe), .data_strobe(data_strobe), .cycle_end(cycle_end),
    .cycle_len(cycle_len), .rate_fast(rate_fast), .rate_odd(rate_odd),
    .quad_error(quad_error), .locked(locked), .phase(phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  // Reference: phase sample captured on clk edge t; outputs appear S edges later.
  // Cycle length is the distance in samples between E falls; stall when >31 samples pass without one.
  task automatic model_step(int ph, int t);
    ev_t e;
    e = '0;
    e.cyc = t + S;
    hist[t] = ph;
    if (mtrack) begin
      if (ph != prev_ph && ph != (prev_ph + 1) % 4) begin
        mtrack = 0;
        lk = 0;
        e.qe = 1;
      end else if (prev_ph == 3 && ph == 0) begin
        mlen = (t - last_fall > MAXL) ? MAXL : t - last_fall;
        mfast = mlen == 8;
        lk = lk < LOCK ? lk + 1 : LOCK;
        last_fall = t;
        e.d = 1;
        e.c = 1;
        e.odd = mlen != 8 && mlen != 16;
      end else if (t - last_fall > MAXL) begin
        mtrack = 0;
        lk = 0;
      end else if (prev_ph == 0 && ph == 1) e.a = 1;
    end else if (prev_ph == 3 && ph == 0) begin
      mtrack = 1;
      last_fall = t;
    end
    if (e.a || e.d || e.qe) begin
      e.len = LW'(mlen);
      e.fast = mfast;
      e.lk = lk == LOCK;
      evq.push_back(e);
    end
    prev_ph = ph;
  endtask

  task automatic put(int ph);
    @(posedge clk);
    #1;
    E = ph >= 2;
    Q = ph == 1 || ph == 2;
    cur_ph = ph;
    model_step(ph, cyc + 1);
  endtask

  task automatic run(int ph, int k);
    for (int i = 0; i < k; i++) put(ph);
  endtask

  task automatic cyc_run(int d0, int d1, int d2, int d3);
    run(0, d0);
    run(1, d1);
    run(2, d2);
    run(3, d3);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1;
    evq.delete();
    hist.delete();
    mtrack = 0;
    prev_ph = 0;
    lk = 0;
    mlen = 0;
    mfast = 0;
    @(negedge clk);
    check("reset_outputs", int'({addr_strobe, data_strobe, cycle_end, rate_fast, rate_odd,
                                 quad_error, locked, cycle_len, phase}), 0);
    @(posedge clk);
    #1;
    reset = 0;
    model_step(cur_ph, cyc + 1);
  endtask

  always @(negedge clk) if (!reset) begin
    exp_ph = hist.exists(cyc - S + 1) ? hist[cyc - S + 1] : 0;
    checks++;
    if (phase != 2'(exp_ph)) begin
      failures++;
      $display("FAIL phase cyc=%0d got=%0d want=%0d", cyc, phase, exp_ph);
    end
    while (evq.size() > 0 && evq[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_event cyc=%0d got=none want_cyc=%0d", cyc, evq[0].cyc);
      void'(evq.pop_front());
    end
    if (addr_strobe || data_strobe || quad_error) begin
      act = {cyc, addr_strobe, data_strobe, cycle_end, quad_error, rate_odd, cycle_len, rate_fast, locked};
      checks++;
      if (evq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d got a/d/qe=%b%b%b want=none", cyc, addr_strobe, data_strobe, quad_error);
      end else begin
        want = evq.pop_front();
        if (act != want) begin
          failures++;
          $display("FAIL event got cyc=%0d a=%b d=%b c=%b qe=%b odd=%b len=%0d fast=%b lk=%b want cyc=%0d a=%b d=%b c=%b qe=%b odd=%b len=%0d fast=%b lk=%b",
                   act.cyc, act.a, act.d, act.c, act.qe, act.odd, act.len, act.fast, act.lk,
                   want.cyc, want.a, want.d, want.c, want.qe, want.odd, want.len, want.fast, want.lk);
        end
      end
    end
  end

  initial begin
    do_reset();
    n = 3 + $urandom_range(0, 2);
    repeat (n) cyc_run(4, 4, 4, 4);
    check("slow_locked", locked, 1);
    check("slow_len", cycle_len, 16);
    cyc_run(4, 4, 2, 2);
    repeat (n) cyc_run(2, 2, 2, 2);
    check("fast_len", cycle_len, 8);
    check("fast_flag", rate_fast, 1);
    run(0, 3);
    put(2);
    run(2, 3);
    run(3, 4);
    repeat (3) cyc_run(2, 2, 2, 2);
    run(0, 40);
    check("timeout_locked", locked, 0);
    run(1, 4);
    run(2, 4);
    run(3, 4);
    repeat (3) cyc_run(4, 4, 4, 4);
    run(0, 4);
    run(1, 4);
    run(2, 2);
    do_reset();
    run(2, 2);
    run(3, 4);
    repeat (3) cyc_run(4, 4, 4, 4);
    for (int i = 0; i < 60; i++) begin
      nx = ($urandom_range(0, 9) == 0) ? (cur_ph + 2 + $urandom_range(0, 1)) % 4 : (cur_ph + 1) % 4;
      run(nx, $urandom_range(1, 4));
    end
    run((cur_ph + 1) % 4, 2);
    while (cur_ph != 3) run((cur_ph + 1) % 4, 2);
    repeat (3) cyc_run(2, 2, 2, 2);
    run(0, S + 4);
    check("events_drained", evq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
